// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: two-digit BCD up/down counter (00..99) stepping every
// TICK_DIV clocks, with a two-slot digit scanner that time-multiplexes the
// ones and tens nibbles onto {w,x,y,z} for a downstream seven_segment decoder.
// All outputs are registered so the decoder never sees a glitching nibble.
// Build option: define BCD_SCAN_BLANK_LEAD_EN to blank a leading zero tens digit.
// o_dbg_slot exposes the scanner FSM state (0 = ONES, 1 = TENS) for checkers.
module bcd_scan_counter #(
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       w,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic [1:0] dig_sel,
  output logic [7:0] count,
  output logic       carry,
  output logic       o_dbg_slot
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  // Scanner FSM states
  localparam logic [0:0] S_ONES = 1'b0;
  localparam logic [0:0] S_TENS = 1'b1;

  logic [TW-1:0] r_tcnt;
  logic [SW-1:0] r_scnt;
  logic [0:0]    r_slot;
  logic [3:0]    r_ones;
  logic [3:0]    r_tens;
  logic          r_carry;
  logic [3:0]    r_nib;
  logic [1:0]    r_dig_sel;

  logic          w_step;
  logic [3:0]    w_ld_ones;
  logic [3:0]    w_ld_tens;
  logic [3:0]    w_nx_ones;
  logic [3:0]    w_nx_tens;
  logic          w_wrap;
  logic [3:0]    w_nib_sel;
  logic [1:0]    w_dig_sel_nx;

  // A step happens only on the last prescaler cycle while enabled.
  assign w_step    = en && (r_tcnt == TICK_LAST);
  // Out-of-range BCD digits saturate to 9 on load.
  assign w_ld_ones = (load_val[3:0] > 4'd9) ? 4'd9 : load_val[3:0];
  assign w_ld_tens = (load_val[7:4] > 4'd9) ? 4'd9 : load_val[7:4];

  // Next BCD value for one step in the sampled direction, flagging a wrap.
  always_comb begin
    w_nx_ones = r_ones;
    w_nx_tens = r_tens;
    w_wrap    = 1'b0;
    if (up) begin
      if (r_ones == 4'd9) begin
        w_nx_ones = 4'd0;
        if (r_tens == 4'd9) begin
          w_nx_tens = 4'd0;
          w_wrap    = 1'b1;
        end else begin
          w_nx_tens = r_tens + 4'd1;
        end
      end else begin
        w_nx_ones = r_ones + 4'd1;
      end
    end else begin
      if (r_ones == 4'd0) begin
        w_nx_ones = 4'd9;
        if (r_tens == 4'd0) begin
          w_nx_tens = 4'd9;
          w_wrap    = 1'b1;
        end else begin
          w_nx_tens = r_tens - 4'd1;
        end
      end else begin
        w_nx_ones = r_ones - 4'd1;
      end
    end
  end

  // Count and prescaler: load wins over a step; enable low freezes both.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcnt  <= '0;
      r_ones  <= 4'd0;
      r_tens  <= 4'd0;
      r_carry <= 1'b0;
    end else begin
      r_carry <= 1'b0;
      if (load) begin
        r_ones <= w_ld_ones;
        r_tens <= w_ld_tens;
        r_tcnt <= '0;
      end else if (w_step) begin
        r_ones  <= w_nx_ones;
        r_tens  <= w_nx_tens;
        r_carry <= w_wrap;
        r_tcnt  <= '0;
      end else if (en) begin
        r_tcnt <= r_tcnt + TW'(1);
      end
    end
  end

  // Free-running scan slot timer and two-state slot FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scnt <= '0;
      r_slot <= S_ONES;
    end else if (r_scnt == SCAN_LAST) begin
      r_scnt <= '0;
      r_slot <= (r_slot == S_ONES) ? S_TENS : S_ONES;
    end else begin
      r_scnt <= r_scnt + SW'(1);
    end
  end

  // Pick the nibble and digit enable for the current slot.
  always_comb begin
    w_nib_sel    = r_ones;
    w_dig_sel_nx = 2'b01;
    if (r_slot == S_TENS) begin
      w_nib_sel    = r_tens;
      w_dig_sel_nx = 2'b10;
`ifdef BCD_SCAN_BLANK_LEAD_EN
      if (r_tens == 4'd0) begin
        w_nib_sel    = 4'd0;
        w_dig_sel_nx = 2'b00;
      end
`endif
    end
  end

  // Register nibble and digit enable together so they switch on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nib     <= 4'd0;
      r_dig_sel <= 2'b01;
    end else begin
      r_nib     <= w_nib_sel;
      r_dig_sel <= w_dig_sel_nx;
    end
  end

  assign {w, x, y, z} = r_nib;
  assign dig_sel      = r_dig_sel;
  assign count        = {r_tens, r_ones};
  assign carry        = r_carry;
  assign o_dbg_slot   = r_slot[0];

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Testbench for bcd_scan_counter with TICK_DIV=4, SCAN_DIV=8.
// Each scenario pushes the expected {count, carry, dig_sel, wxyz} for the
// coming edge onto exp_q, then pops and compares it one time unit after the edge.
module tb_bcd_scan_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic       w, x, y, z;
  logic [1:0] dig_sel;
  logic [7:0] count;
  logic       carry;
  logic       dbg_slot;

  int n_checks = 0;
  int n_fails  = 0;
  logic [14:0] exp_q[$];

  // clock
  always #5 clk = ~clk;

  bcd_scan_counter #(.TICK_DIV(4), .SCAN_DIV(8)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .w(w), .x(x), .y(y), .z(z), .dig_sel(dig_sel), .count(count),
    .carry(carry), .o_dbg_slot(dbg_slot)
  );

  function automatic logic [7:0] to_bcd(input int d);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(d / 10);
    o = 4'(d % 10);
    return {t, o};
  endfunction

  // Expected packed outputs after edge k (k counted from reset release):
  // the display registers show the count held before that edge, in the slot
  // that was active during the previous cycle (ONES for 8 cycles, then TENS).
  function automatic logic [14:0] exp_vec(input logic [7:0] c_now, input logic cy,
                                          input logic [7:0] c_prev, input int k);
    logic [1:0] ds;
    logic [3:0] nib;
    if (((k - 1) % 16) < 8) begin
      ds  = 2'b01;
      nib = c_prev[3:0];
    end else begin
      ds  = 2'b10;
      nib = c_prev[7:4];
`ifdef BCD_SCAN_BLANK_LEAD_EN
      if (c_prev[7:4] == 4'd0) begin
        ds  = 2'b00;
        nib = 4'd0;
      end
`endif
    end
    return {c_now, cy, ds, nib};
  endfunction

  // driver tasks
  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
    repeat (2) clk_step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [14:0] got, want;
    logic [7:0]  now;
    rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; load_val = 8'h00;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back({8'h00, 1'b0, 2'b01, 4'h0});
      clk_step();
      got = {count, carry, dig_sel, w, x, y, z};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fails++;
        $display("FAIL reset_hold k=%0d got cnt=%h cy=%b sel=%b nib=%b want cnt=%h cy=%b sel=%b nib=%b",
                 k, got[14:7], got[6], got[5:4], got[3:0], want[14:7], want[6], want[5:4], want[3:0]);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      now = (k == 4) ? 8'h01 : 8'h00;
      exp_q.push_back(exp_vec(now, 1'b0, 8'h00, k));
      clk_step();
      got = {count, carry, dig_sel, w, x, y, z};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fails++;
        $display("FAIL reset_release k=%0d got cnt=%h cy=%b sel=%b nib=%b want cnt=%h cy=%b sel=%b nib=%b",
                 k, got[14:7], got[6], got[5:4], got[3:0], want[14:7], want[6], want[5:4], want[3:0]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [14:0] got, want;
    logic [7:0]  now;
    reset_dut();
    en = 1'b1; up = 1'b1; load = 1'b1; load_val = 8'h45;
    clk_step();
    load = 1'b0;
    repeat (5) clk_step();
    rst = 1'b1;
    exp_q.push_back({8'h00, 1'b0, 2'b01, 4'h0});
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin
        now = (k == 4) ? 8'h01 : 8'h00;
        exp_q.push_back(exp_vec(now, 1'b0, 8'h00, k));
      end
      clk_step();
      rst = 1'b0;
      got = {count, carry, dig_sel, w, x, y, z};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fails++;
        $display("FAIL reset_midrun k=%0d got cnt=%h cy=%b sel=%b nib=%b want cnt=%h cy=%b sel=%b nib=%b",
                 k, got[14:7], got[6], got[5:4], got[3:0], want[14:7], want[6], want[5:4], want[3:0]);
      end
    end
  endtask

  // Load a decimal start value, then count in one direction for n edges.
  task automatic test_count_from_load(input string name, input int start, input logic dir, input int n);
    logic [14:0] got, want;
    logic [7:0]  now, prev;
    logic        cy;
    int          j, d;
    reset_dut();
    en = 1'b1; up = dir; prev = 8'h00;
    for (int k = 1; k <= n; k++) begin
      load = (k == 1);
      load_val = to_bcd(start);
      j = (k - 1) / 4;
      d = dir ? (start + j) % 100 : (((start - j) % 100) + 100) % 100;
      cy = (k > 1) && ((k - 1) % 4 == 0) && ((dir && d == 0) || (!dir && d == 99));
      now = to_bcd(d);
      exp_q.push_back(exp_vec(now, cy, prev, k));
      clk_step();
      load = 1'b0;
      got = {count, carry, dig_sel, w, x, y, z};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fails++;
        $display("FAIL %s start=%0d up=%b k=%0d got cnt=%h cy=%b sel=%b nib=%b want cnt=%h cy=%b sel=%b nib=%b",
                 name, start, dir, k, got[14:7], got[6], got[5:4], got[3:0], want[14:7], want[6], want[5:4], want[3:0]);
      end
      prev = now;
    end
  endtask

  task automatic test_load_priority();
    logic [14:0] got, want;
    logic [7:0]  now, prev;
    reset_dut();
    en = 1'b1; up = 1'b1; load_val = 8'hAB; prev = 8'h00;
    for (int k = 1; k <= 10; k++) begin
      load = (k == 4);
      now = (k <= 3) ? 8'h00 : (k <= 7) ? 8'h99 : 8'h00;
      exp_q.push_back(exp_vec(now, (k == 8), prev, k));
      clk_step();
      got = {count, carry, dig_sel, w, x, y, z};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fails++;
        $display("FAIL load_priority k=%0d got cnt=%h cy=%b sel=%b nib=%b want cnt=%h cy=%b sel=%b nib=%b",
                 k, got[14:7], got[6], got[5:4], got[3:0], want[14:7], want[6], want[5:4], want[3:0]);
      end
      prev = now;
    end
    load = 1'b0;
  endtask

  task automatic test_enable_freeze();
    logic [14:0] got, want;
    logic [7:0]  now, prev;
    reset_dut();
    up = 1'b1; prev = 8'h00;
    for (int k = 1; k <= 20; k++) begin
      en = (k <= 2) || (k >= 13);
      now = (k < 14) ? 8'h00 : (k < 18) ? 8'h01 : 8'h02;
      exp_q.push_back(exp_vec(now, 1'b0, prev, k));
      clk_step();
      got = {count, carry, dig_sel, w, x, y, z};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fails++;
        $display("FAIL enable_freeze k=%0d got cnt=%h cy=%b sel=%b nib=%b want cnt=%h cy=%b sel=%b nib=%b",
                 k, got[14:7], got[6], got[5:4], got[3:0], want[14:7], want[6], want[5:4], want[3:0]);
      end
      prev = now;
    end
  endtask

  task automatic test_scan_blank();
    logic [14:0] got, want;
    logic [7:0]  prev;
    reset_dut();
    en = 1'b0; load_val = 8'h07; prev = 8'h00;
    for (int k = 1; k <= 40; k++) begin
      load = (k == 1);
      up = 1'($urandom_range(0, 1));
      exp_q.push_back(exp_vec(8'h07, 1'b0, prev, k));
      clk_step();
      got = {count, carry, dig_sel, w, x, y, z};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fails++;
        $display("FAIL scan_blank k=%0d got cnt=%h cy=%b sel=%b nib=%b want cnt=%h cy=%b sel=%b nib=%b",
                 k, got[14:7], got[6], got[5:4], got[3:0], want[14:7], want[6], want[5:4], want[3:0]);
      end
      prev = 8'h07;
    end
    load = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [14:0] got, want;
    logic [7:0]  now, prev;
    reset_dut();
    en = 1'b1; up = 1'b0; prev = 8'h00;
    for (int k = 1; k <= 12; k++) begin
      load = (k <= 3);
      load_val = (k == 1) ? 8'h12 : (k == 2) ? 8'h34 : 8'h56;
      now = (k == 1) ? 8'h12 : (k == 2) ? 8'h34 : (k <= 6) ? 8'h56 : (k <= 10) ? 8'h55 : 8'h54;
      exp_q.push_back(exp_vec(now, 1'b0, prev, k));
      clk_step();
      got = {count, carry, dig_sel, w, x, y, z};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fails++;
        $display("FAIL back_to_back k=%0d got cnt=%h cy=%b sel=%b nib=%b want cnt=%h cy=%b sel=%b nib=%b",
                 k, got[14:7], got[6], got[5:4], got[3:0], want[14:7], want[6], want[5:4], want[3:0]);
      end
      prev = now;
    end
    load = 1'b0;
  endtask

  task automatic test_random();
    int   start;
    logic dir;
    for (int it = 0; it < 6; it++) begin
      start = int'($urandom_range(0, 99));
      dir   = 1'($urandom_range(0, 1));
      test_count_from_load("random", start, dir, 14);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
    test_reset();
    test_reset_midrun();
    test_count_from_load("up_wrap", 98, 1'b1, 12);
    test_count_from_load("down_wrap", 10, 1'b0, 48);
    test_load_priority();
    test_enable_freeze();
    test_scan_blank();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/bcd_scan_counter.md
# bcd_scan_counter

Two-digit BCD up/down counter with a built-in digit scanner, sitting directly upstream of `seven_segment`. It steps a 00–99 count at a programmable tick rate. It time-multiplexes the ones and tens digits onto the 4-bit `w,x,y,z` bus that the decoder consumes, and provides a one-hot digit select for the display common lines. All outputs are registered, so the decoder sees glitch-free nibbles.

## Interface
Parameters:
- `TICK_DIV`, 50_000_000: clocks per count step; legal ≥ 2.
- `SCAN_DIV`, 100_000: clocks per digit scan slot; legal ≥ 2.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `en`, in, 1: count enable; low freezes both the count and the tick prescaler.
- `up`, in, 1: direction; 1 counts up, 0 counts down.
- `load`, in, 1: synchronous load strobe.
- `load_val`, in, 8: BCD load value, with tens in [7:4] and ones in [3:0].
- `w, x, y, z`, out, 1 each: selected digit nibble to the decoder; `w` is the MSB.
- `dig_sel`, out, 2: one-hot active-high digit enable; bit0 is ones, bit1 is tens.
- `count`, out, 8: current BCD count.
- `carry`, out, 1: one-cycle pulse on wrap, in either direction.

## Operation
- Tick prescaler `tcnt` counts 0..TICK_DIV-1 while `en`=1 and holds while `en`=0.
  - A step occurs on the cycle where `tcnt`=TICK_DIV-1 and `en`=1.
  - On that cycle `tcnt` returns to 0.
- Step up:
  - ones+1; if ones is 9, ones←0 and tens+1.
  - 99 → 00 with `carry`=1.
- Step down:
  - ones-1; if ones is 0, ones←9 and tens-1.
  - 00 → 99 with `carry`=1.
- Load:
  - `load`=1 sets `count`←`load_val` and `tcnt`←0, overriding any simultaneous step.
  - `carry` stays 0 on a load.
  - Any nibble >9 is loaded as 9; e.g. 0xA3 loads as 0x93.
- `up` is sampled only on step cycles; changing it mid-interval is legal.
- Scanner counter `scnt` counts 0..SCAN_DIV-1, free-running and independent of `en` and `load`.
  - At SCAN_DIV-1 the slot toggles between ONES and TENS; the FSM has these two states only.
- Output register each cycle:
  - `{w,x,y,z}` ← nibble of `count` for the current slot.
  - `dig_sel` ← 2'b01 in ONES, 2'b10 in TENS.
- Reset values:
  - `count`=8'h00, `tcnt`=0, `scnt`=0, slot=ONES.
  - `dig_sel`=2'b01, `{w,x,y,z}`=4'b0000, `carry`=0.
- Reset mid-count or mid-slot discards all state; there is no partial step.

## Timing
- `count` and `carry` update on the clock edge that ends the step cycle; `carry` stays high for exactly one cycle.
- `{w,x,y,z}` and `dig_sel` lag the internal count/slot by 1 cycle.
  - A count change is visible on the nibble bus 2 edges after the step cycle, if its digit is selected.
- Slot switch:
  - `dig_sel` and `{w,x,y,z}` change on the same edge, never on separate cycles.
  - No cycle ever shows both bits of `dig_sel` set, or the wrong nibble for the active digit.
- Load then step: the first step after a load occurs TICK_DIV cycles after the load cycle, provided `en`=1 throughout.

## Configuration
- `BCD_SCAN_BLANK_LEAD_EN` defined:
  - Leading-zero blanking. In the TENS slot with tens=0, `dig_sel`=2'b00 and `{w,x,y,z}`=4'b0000.
  - The ONES digit is always shown.
- Undefined: tens is always driven, so "07" shows both digits.
- Counting, `count`, and `carry` are identical in both builds.

## Test plan
- Reset, with TICK_DIV=4 and SCAN_DIV=8: hold `rst` 3 cycles → `count`=00, `dig_sel`=01, `wxyz`=0000, `carry`=0, all held every cycle after release until the first tick.
- Up wrap:
  - Load 0x98 with `up`=1, `en`=1 → 0x99 after 4 clocks, 0x00 after 8 clocks with a single-cycle `carry`.
  - `wxyz` in the ONES slot reads 1000, 1001, then 0000.
- Down wrap: load 0x10 with `up`=0 → 0x09, then 0x08, …, 0x00, then 0x99 with `carry`=1 exactly once.
- Load priority and clamp:
  - Assert `load` with 0xAB on a tick cycle → `count`=0x99, no step, `carry`=0.
  - The next step follows 4 cycles later.
- Enable freeze: drop `en` for 10 cycles mid-interval → `count` and `tcnt` hold; the step resumes with the remaining tick count; `scnt`/`dig_sel` keep toggling every 8 cycles.
- Scan and blank:
  - `count`=0x07 → `dig_sel` alternates 01/10 every 8 cycles with `wxyz` 0111/0000.
  - With `BCD_SCAN_BLANK_LEAD_EN`, the TENS slot shows `dig_sel`=00.
